denormalize_pack: RTL
=====================

DENORMALIZE_PACK -- requirements
Module: denormalize_pack

Interface
REQ-001 SHALL have parameter THRESH, default 308_960, meaning the signed fixed-point binarization threshold (17 fractional bits; midpoint of the two normalized levels 644_573 and -26_653).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of packed rows buffered (power of two, at least 2).
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock for the block.
REQ-004 SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pixel_in, input, signed 21 bits: normalized pixel value.
REQ-006 SHALL have ports hcount_in and vcount_in, input, 5 bits each: column and row of pixel_in within the 32x32 frame.
REQ-007 SHALL have port data_valid_in, input, 1 bit: active-high qualifier for pixel_in, hcount_in and vcount_in.
REQ-008 SHALL have port row_data_out, output, 32 bits: packed binary row, where bit k corresponds to column k.
REQ-009 SHALL have port row_idx_out, output, 5 bits: row number of row_data_out.
REQ-010 SHALL have port row_valid_out, output, 1 bit, and port row_ready_in, input, 1 bit: the valid/ready handshake for row output.
REQ-011 SHALL have port frame_done_out, output, 1 bit: one-cycle pulse.
REQ-012 SHALL have ports seq_err_out and overflow_out, output, 1 bit each: sticky error flags.

Function
REQ-013 SHALL compute each pixel's bit as 1 when pixel_in >= THRESH (signed 21-bit comparison) and 0 otherwise.
REQ-014 SHALL accept a pixel only on cycles where data_valid_in=1, and SHALL write its bit into the row accumulator at index hcount_in.
REQ-015 SHALL track the expected coordinates (exp_h, exp_v), which advance in raster order and wrap from (31,31) to (0,0).
REQ-016 SHALL, when an accepted pixel's coordinates differ from (exp_h, exp_v), set seq_err_out and resynchronize the expected coordinates to the pixel's coordinates plus one.
REQ-017 SHALL, when the accepted pixel has hcount_in=31, push {vcount_in, accumulator including this bit} into the FIFO on the same clock edge, then clear the accumulator.
REQ-018 SHALL present the FIFO head show-ahead: row_valid_out=1 whenever the FIFO is non-empty, so row_valid_out rises the cycle after the last pixel of a row is accepted into an empty FIFO (latency 1).
REQ-019 SHALL count a transfer only on a cycle where row_valid_out=1 and row_ready_in=1.
REQ-020 SHALL hold row_data_out and row_idx_out stable while row_valid_out=1 and row_ready_in=0.
REQ-021 SHALL allow a push and a pop in the same cycle, including when the FIFO is full, with occupancy unchanged in that case.
REQ-022 SHALL, on a push to a full FIFO with no simultaneous pop, drop the row, set overflow_out, and leave the FIFO contents unchanged.
REQ-023 SHALL, on an empty FIFO, ignore row_ready_in with no state change.
REQ-024 SHALL pulse frame_done_out for exactly one cycle, on the cycle after a transfer with row_idx_out=31.
REQ-025 SHALL keep seq_err_out and overflow_out set until reset.

Reset
REQ-026 SHALL, while rst_in=1, asynchronously force: FIFO empty, row_valid_out=0, row_data_out=0, row_idx_out=0, frame_done_out=0, seq_err_out=0, overflow_out=0, accumulator=0, and expected coordinates=(0,0).
REQ-027 SHALL, when reset is asserted mid-row, discard the partial row and all buffered rows, and SHALL raise no error flag on the first pixel after reset if that pixel is at (0,0).

Structure
REQ-028 SHALL take FRAME_DIM=32, COORD_W=5, PIX_W=21, and the normalized level constants HI=644_573, LO=-26_653 (with THRESH derived as (HI+LO)/2) from the shared image package img_pkg.
REQ-029 SHALL implement the FIFO as one sub-module, row_fifo, parameterized by width (37 bits) and depth, with async reset and show-ahead read.

Verification
REQ-030 SHALL verify: a full frame alternating 644_573 / -26_653 per column, with row_ready_in=1 -> 32 rows each 0x55555555, row_idx_out 0..31, one frame_done_out pulse, no error flags.
REQ-031 SHALL verify: pixel values 308_960, 308_959, -1048576, and 1048575 at columns 0..3 (rest LO) -> row word 0x00000009.
REQ-032 SHALL verify: row_ready_in=0 for 5 complete rows with FIFO_DEPTH=4 -> 4 rows held stable, overflow_out=1, and later drain yields rows 0..3 only.
REQ-033 SHALL verify: a frame with column 10 of row 2 skipped -> seq_err_out=1, row 2 still pushed at hcount 31, and subsequent rows correct.
REQ-034 SHALL verify: FIFO full with a push and pop in the same cycle -> no overflow and occupancy stays 4.
REQ-035 SHALL verify: rst_in pulsed at row 7 column 15 -> all outputs return to zero immediately, and a restarted frame from (0,0) completes cleanly.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image constants for the 32x32 normalized-pixel pipeline.
// Also holds the packed row word layout and the raster coordinate stepping.
package img_pkg;

  localparam int FRAME_DIM  = 32;
  localparam int COORD_W    = 5;
  localparam int PIX_W      = 21;
  localparam int HI         = 644_573;
  localparam int LO         = -26_653;
  localparam int THRESH_MID = (HI + LO) / 2;
  localparam int ROW_W      = COORD_W + FRAME_DIM;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t               idx;
    logic [FRAME_DIM-1:0] bits;
  } row_word_t;

  // {v,h} treated as one counter steps in raster order and wraps (31,31)->(0,0)
  function automatic logic [2*COORD_W-1:0] raster_next(input coord_t h, input coord_t v);
    return {v, h} + (2*COORD_W)'(1);
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Show-ahead FIFO for packed rows; the head is visible whenever non-empty.
// Push is accepted when full only if a pop happens on the same edge.
module row_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty_out,
  output logic             full_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty_out = (count_reg == '0);
  assign full_out  = (count_reg == CW'(DEPTH));
  assign do_pop    = pop_in && !empty_out;
  assign do_push   = push_in && (!full_out || do_pop);

  // Storage is not reset; the output is masked while empty instead.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign data_out = empty_out ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/denormalize_pack.sv
// Binarizes normalized pixels against a threshold and packs each row into a
// 32-bit word, buffered in a small FIFO behind a valid/ready handshake.
module denormalize_pack
  import img_pkg::*;
#(
  parameter int THRESH     = img_pkg::THRESH_MID,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [PIX_W-1:0] pixel_in,
  input  logic [COORD_W-1:0]      hcount_in,
  input  logic [COORD_W-1:0]      vcount_in,
  input  logic                    data_valid_in,
  output logic [FRAME_DIM-1:0]    row_data_out,
  output logic [COORD_W-1:0]      row_idx_out,
  output logic                    row_valid_out,
  input  logic                    row_ready_in,
  output logic                    frame_done_out,
  output logic                    seq_err_out,
  output logic                    overflow_out
);

  localparam logic signed [PIX_W-1:0] THRESH_Q = PIX_W'(THRESH);
  localparam coord_t LAST = COORD_W'(FRAME_DIM - 1);

  logic [FRAME_DIM-1:0] acc_reg;
  logic [FRAME_DIM-1:0] row_bits;
  coord_t               exp_h_reg;
  coord_t               exp_v_reg;
  logic                 seq_err_reg;
  logic                 overflow_reg;
  logic                 frame_done_reg;

  logic                 pix_bit;
  logic                 row_push;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [ROW_W-1:0]     fifo_dout;
  row_word_t            push_word;
  row_word_t            head_word;

  assign pix_bit  = (pixel_in >= THRESH_Q);
  assign row_push = data_valid_in && (hcount_in == LAST);

  // Row including the current pixel, so the last column lands in the pushed word.
  always_comb begin
    row_bits            = acc_reg;
    row_bits[hcount_in] = pix_bit;
  end

  assign push_word.idx  = vcount_in;
  assign push_word.bits = row_bits;

  row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (row_push),
    .data_in   (push_word),
    .pop_in    (row_ready_in),
    .data_out  (fifo_dout),
    .empty_out (fifo_empty),
    .full_out  (fifo_full)
  );

  assign head_word = fifo_dout;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_reg        <= '0;
      exp_h_reg      <= '0;
      exp_v_reg      <= '0;
      seq_err_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (data_valid_in) begin
        acc_reg                <= row_push ? '0 : row_bits;
        // Resync to the pixel actually seen, whether or not it was expected
        {exp_v_reg, exp_h_reg} <= raster_next(hcount_in, vcount_in);
        if (hcount_in != exp_h_reg || vcount_in != exp_v_reg) begin
          seq_err_reg <= 1'b1;
        end
      end
      if (row_push && fifo_full && !row_ready_in) begin
        overflow_reg <= 1'b1;
      end
      frame_done_reg <= row_ready_in && !fifo_empty && (head_word.idx == LAST);
    end
  end

  assign row_valid_out  = !fifo_empty;
  assign row_data_out   = head_word.bits;
  assign row_idx_out    = head_word.idx;
  assign frame_done_out = frame_done_reg;
  assign seq_err_out    = seq_err_reg;
  assign overflow_out   = overflow_reg;

endmodule
